// File: rtl/mult_arbiter_if.sv
// Handshake and operand/result bundle between the compute units and the mult_arbiter bank.
interface mult_arbiter_if;
  logic        req_T;
  logic        rel_T;
  logic [95:0] T_op1;
  logic [95:0] T_op2;
  logic        req_S;
  logic        rel_S;
  logic [95:0] S_op1;
  logic [95:0] S_op2;
  logic        gnt_T;
  logic        gnt_S;
  logic [95:0] mult_result;
  logic        res_valid;
  logic        busy;
  logic        hold_err;

  modport master (
    output req_T, rel_T, T_op1, T_op2, req_S, rel_S, S_op1, S_op2,
    input  gnt_T, gnt_S, mult_result, res_valid, busy, hold_err
  );

  modport slave (
    input  req_T, rel_T, T_op1, T_op2, req_S, rel_S, S_op1, S_op2,
    output gnt_T, gnt_S, mult_result, res_valid, busy, hold_err
  );
endinterface

// File: rtl/mult_arbiter.sv
// Two-requester arbiter for a shared 3-lane 32x32 signed multiplier bank.
// Define MULT_PIPE_EN to register mult_result/res_valid (1-cycle latency).
module mult_arbiter #(
  parameter logic [9:0] MAX_HOLD = 10'd1023
) (
  input  logic          Clock_50,
  input  logic          Reset,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ArbIdle, ArbT, ArbS, ArbGap} arb_state_e;

  arb_state_e  state_q, state_d;
  logic        last_owner_q;  // 1: S owned last, so T wins the next tie
  logic [9:0]  hold_cnt_q;
  logic        hold_err_q;
  logic        owned;
  logic        entering;
  logic [95:0] op1, op2, prod;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ArbIdle: begin
        if (bus.req_T && bus.req_S) state_d = last_owner_q ? ArbT : ArbS;
        else if (bus.req_T)         state_d = ArbT;
        else if (bus.req_S)         state_d = ArbS;
      end
      ArbT:    if (bus.rel_T) state_d = ArbGap;
      ArbS:    if (bus.rel_S) state_d = ArbGap;
      ArbGap:  state_d = ArbIdle;
      default: state_d = ArbIdle;
    endcase
  end

  assign owned    = (state_q == ArbT) || (state_q == ArbS);
  assign entering = (state_q == ArbIdle) && (state_d != ArbIdle);

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      state_q      <= ArbIdle;
      last_owner_q <= 1'b1;
      hold_cnt_q   <= '0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (entering) begin
        last_owner_q <= (state_d == ArbS);
        hold_cnt_q   <= '0;
      end else if (owned && hold_cnt_q != MAX_HOLD) begin
        hold_cnt_q <= hold_cnt_q + 10'd1;
      end
      if (owned && hold_cnt_q == MAX_HOLD) hold_err_q <= 1'b1;
    end
  end

  // Only the owner's operands reach the multipliers; everything else sees zero.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if (state_q == ArbT) begin
      op1 = bus.T_op1;
      op2 = bus.T_op2;
    end else if (state_q == ArbS) begin
      op1 = bus.S_op1;
      op2 = bus.S_op2;
    end
  end

  // Low 32 bits of a signed product equal those of the unsigned product.
  assign prod[95:64] = op1[95:64] * op2[95:64];
  assign prod[63:32] = op1[63:32] * op2[63:32];
  assign prod[31:0]  = op1[31:0]  * op2[31:0];

  assign bus.gnt_T    = (state_q == ArbT);
  assign bus.gnt_S    = (state_q == ArbS);
  assign bus.busy     = (state_q != ArbIdle);
  assign bus.hold_err = hold_err_q;

`ifdef MULT_PIPE_EN
  logic [95:0] res_q;
  logic        valid_q;

  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= prod;
      valid_q <= owned;
    end
  end

  assign bus.mult_result = res_q;
  assign bus.res_valid   = valid_q;
`else
  assign bus.mult_result = prod;
  assign bus.res_valid   = owned;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: ownership model plus directed literal checks.
module tb_mult_arbiter;
  localparam logic [9:0] MaxHold = 10'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mult_arbiter_if bus ();

  mult_arbiter #(.MAX_HOLD(MaxHold)) dut (
    .Clock_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  // Model: owner 0=none 1=T 2=S; m_len counts owned cycles including the current one.
  int          m_owner = 0;
  bit          m_gap   = 1'b0;
  int          m_last  = 2;
  int          m_len   = 0;
  bit          m_err   = 1'b0;
  logic [95:0] m_pres  = '0;
  bit          m_pv    = 1'b0;

  function automatic logic [95:0] prod3(input logic [95:0] x, input logic [95:0] y);
    logic [95:0]        r;
    logic signed [63:0] p;
    for (int i = 0; i < 3; i++) begin
      p = 64'($signed(x[32*i +: 32])) * 64'($signed(y[32*i +: 32]));
      r[32*i +: 32] = p[31:0];
    end
    return r;
  endfunction

  function automatic logic [95:0] sel_prod(input int owner);
    if (owner == 1) return prod3(bus.T_op1, bus.T_op2);
    if (owner == 2) return prod3(bus.S_op1, bus.S_op2);
    return '0;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [95:0] p;
    int          w;
    p = sel_prod(m_owner);
    w = 0;
    if (rst) begin
      m_owner = 0; m_gap = 1'b0; m_last = 2; m_len = 0; m_err = 1'b0;
      m_pres = '0; m_pv = 1'b0;
    end else begin
      m_pres = p;
      m_pv   = (m_owner != 0);
      if (m_owner != 0 && m_len >= int'(MaxHold) + 1) m_err = 1'b1;
      if (m_owner == 1) begin
        if (bus.rel_T) begin m_owner = 0; m_gap = 1'b1; end
        else m_len++;
      end else if (m_owner == 2) begin
        if (bus.rel_S) begin m_owner = 0; m_gap = 1'b1; end
        else m_len++;
      end else if (m_gap) begin
        m_gap = 1'b0;
      end else begin
        if (bus.req_T && bus.req_S) w = (m_last == 1) ? 2 : 1;
        else if (bus.req_T)         w = 1;
        else if (bus.req_S)         w = 2;
        if (w != 0) begin m_owner = w; m_last = w; m_len = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("gnt_T", bus.gnt_T, m_owner == 1);
      chk("gnt_S", bus.gnt_S, m_owner == 2);
      chk("busy", bus.busy, (m_owner != 0) || m_gap);
      chk("hold_err", bus.hold_err, m_err);
`ifdef MULT_PIPE_EN
      chk("res_valid", bus.res_valid, m_pv);
      chk("mult_result", bus.mult_result, m_pres);
`else
      chk("res_valid", bus.res_valid, m_owner != 0);
      chk("mult_result", bus.mult_result, sel_prod(m_owner));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_T = 0; bus.rel_T = 0; bus.T_op1 = '0; bus.T_op2 = '0;
    bus.req_S = 0; bus.rel_S = 0; bus.S_op1 = '0; bus.S_op2 = '0;
    rst = 1;
    step();
    cmp_en = 1;
    step();
    chk("lit_reset_gnt_T", bus.gnt_T, 1'b0);
    chk("lit_reset_busy", bus.busy, 1'b0);
    chk("lit_reset_valid", bus.res_valid, 1'b0);
    rst = 0;

    // First grant and lane arithmetic, including wrap on overflow.
    bus.req_T = 1;
    bus.T_op1 = {32'd3, 32'd10, 32'h7FFF_FFFF};
    bus.T_op2 = {32'hFFFF_FFFB, 32'd20, 32'd2};
    step();
    chk("lit_first_gnt_T", bus.gnt_T, 1'b1);
`ifdef MULT_PIPE_EN
    step();
`endif
    chk("lit_lane_a", bus.mult_result[95:64], 32'hFFFF_FFF1);
    chk("lit_lane_b", bus.mult_result[63:32], 32'd200);
    chk("lit_lane_c", bus.mult_result[31:0], 32'hFFFF_FFFE);
    bus.rel_T = 1;
    step();
    bus.rel_T = 0; bus.req_T = 0;
    step();

    // Tie after reset goes to T; S granted 3 cycles after T's release sample.
    rst = 1;
    step();
    rst = 0;
    bus.S_op1 = {32'd1, 32'd7, 32'd9};
    bus.S_op2 = {32'd1, 32'd6, 32'd3};
    bus.req_T = 1; bus.req_S = 1;
    step();
    chk("lit_tie_gnt_T", bus.gnt_T, 1'b1);
    chk("lit_tie_gnt_S", bus.gnt_S, 1'b0);
    bus.rel_T = 1; bus.req_T = 0;
    step();
    bus.rel_T = 0;
    chk("lit_gap_busy", bus.busy, 1'b1);
    chk("lit_gap_gnt_S", bus.gnt_S, 1'b0);
    step();
    chk("lit_idle_busy", bus.busy, 1'b0);
    step();
    chk("lit_turnaround_gnt_S", bus.gnt_S, 1'b1);

    // Non-owner traffic must not disturb S's result.
    bus.req_T = 1;
    for (int i = 0; i < 6; i++) begin
      bus.T_op1 = {$urandom, $urandom, $urandom};
      bus.T_op2 = {$urandom, $urandom, $urandom};
      bus.rel_T = 1'($urandom_range(0, 1));
      step();
      chk("lit_s_lane_b", bus.mult_result[63:32], 32'd42);
      chk("lit_s_no_gnt_T", bus.gnt_T, 1'b0);
    end
    bus.rel_T = 0;

    // Reset mid-grant, then T wins the tie and trips the hold limit.
    rst = 1;
    step();
    chk("lit_rst_gnt_S", bus.gnt_S, 1'b0);
    chk("lit_rst_busy", bus.busy, 1'b0);
    chk("lit_rst_valid", bus.res_valid, 1'b0);
    chk("lit_rst_hold_err", bus.hold_err, 1'b0);
    rst = 0;
    step();
    chk("lit_post_rst_gnt_T", bus.gnt_T, 1'b1);
    for (int i = 1; i <= 4; i++) step();
    chk("lit_hold_err_idx4", bus.hold_err, 1'b0);
    step();
    chk("lit_hold_err_idx5", bus.hold_err, 1'b1);
    bus.rel_T = 1; bus.req_T = 0;
    step();
    bus.rel_T = 0;
    chk("lit_hold_err_gap", bus.hold_err, 1'b1);
    step();
    step();
    chk("lit_s_after_t", bus.gnt_S, 1'b1);
    chk("lit_hold_err_sticky", bus.hold_err, 1'b1);

    // Release together with request: gap, idle, then same requester again.
    bus.rel_S = 1;
    step();
    bus.rel_S = 0;
    chk("lit_relreq_gnt_S", bus.gnt_S, 1'b0);
    chk("lit_relreq_busy", bus.busy, 1'b1);
`ifdef MULT_PIPE_EN
    chk("lit_gap_valid", bus.res_valid, 1'b1);
`else
    chk("lit_gap_valid", bus.res_valid, 1'b0);
`endif
    step();
    chk("lit_relreq_idle", bus.busy, 1'b0);
    step();
    chk("lit_regrant_S", bus.gnt_S, 1'b1);
    bus.req_S = 0; bus.rel_S = 1;
    step();
    bus.rel_S = 0;
    step();
    step();
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
